// File: rtl/motor_pkg.sv
// Shared types and helpers for the motor PWM decode path: channel classification and the
// conversion from a classified channel plus a duty count to a signed command value.
package motor_pkg;

  localparam int unsigned MEAS_W = 11;

  typedef enum logic [2:0] {
    COAST,
    FWD,
    REV,
    BRAKE,
    FAULT
  } chan_state_t;

  // Only FWD and REV carry a magnitude; every other class reports zero.
  function automatic logic signed [MEAS_W-1:0] state_to_meas(chan_state_t st,
                                                             logic [MEAS_W-1:0] cnt);
    logic signed [MEAS_W-1:0] meas;
    meas = '0;
    case (st)
      FWD:     meas = signed'(cnt);
      REV:     meas = -signed'(cnt);
      default: meas = '0;
    endcase
    return meas;
  endfunction

endpackage

// File: rtl/motor_chan_meas.sv
// One H-bridge side: optional input synchronizer, forward/reverse high-time accumulators,
// window-end classification and the registered meas/brk/flt results.
// Optional feature: MOTOR_DECODE_SYNC_EN adds a 2-flop synchronizer on both drive lines.
module motor_chan_meas
  import motor_pkg::*;
#(
  parameter int unsigned WIN_W = 10
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               fwd_i,
  input  logic               rev_i,
  input  logic               win_end_i,
  output logic signed [WIN_W:0] meas_o,
  output logic               brk_o,
  output logic               flt_o
);

  localparam int unsigned CntW = WIN_W + 1;
  localparam logic [CntW-1:0] Full = CntW'(1) << WIN_W;

  logic fwd_s, rev_s;

`ifdef MOTOR_DECODE_SYNC_EN
  logic [1:0] fwd_sync_q, rev_sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fwd_sync_q <= '0;
      rev_sync_q <= '0;
    end else begin
      fwd_sync_q <= {fwd_sync_q[0], fwd_i};
      rev_sync_q <= {rev_sync_q[0], rev_i};
    end
  end

  assign fwd_s = fwd_sync_q[1];
  assign rev_s = rev_sync_q[1];
`else
  assign fwd_s = fwd_i;
  assign rev_s = rev_i;
`endif

  logic [CntW-1:0] fc_q, fc_d, rc_q, rc_d;
  logic [CntW-1:0] fc_tot, rc_tot, cnt_sel, cnt_sat;
  chan_state_t     state;
  logic signed [WIN_W:0] meas_q, meas_d;
  logic            brk_q, brk_d, flt_q, flt_d;

  // Totals include the current cycle's sample so the closing cycle is never lost.
  assign fc_tot = fc_q + CntW'(fwd_s);
  assign rc_tot = rc_q + CntW'(rev_s);

  always_comb begin
    state = FAULT;
    if (fc_tot == Full && rc_tot == Full) begin
      state = BRAKE;
    end else if (rc_tot == '0) begin
      state = (fc_tot == '0) ? COAST : FWD;
    end else if (fc_tot == '0) begin
      state = REV;
    end
  end

  always_comb begin
    cnt_sel = (state == REV) ? rc_tot : fc_tot;
    cnt_sat = (cnt_sel == Full) ? Full - CntW'(1) : cnt_sel;
  end

  always_comb begin
    fc_d   = win_end_i ? '0 : fc_tot;
    rc_d   = win_end_i ? '0 : rc_tot;
    meas_d = meas_q;
    brk_d  = brk_q;
    flt_d  = flt_q;
    if (win_end_i) begin
      meas_d = CntW'(state_to_meas(state, MEAS_W'(cnt_sat)));
      brk_d  = (state == BRAKE);
      flt_d  = (state == FAULT);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fc_q   <= '0;
      rc_q   <= '0;
      meas_q <= '0;
      brk_q  <= 1'b0;
      flt_q  <= 1'b0;
    end else begin
      fc_q   <= fc_d;
      rc_q   <= rc_d;
      meas_q <= meas_d;
      brk_q  <= brk_d;
      flt_q  <= flt_d;
    end
  end

  assign meas_o = meas_q;
  assign brk_o  = brk_q;
  assign flt_o  = flt_q;

endmodule

// File: rtl/motor_pwm_decode.sv
// Recovers signed left/right motor commands from the four H-bridge drive lines by measuring
// PWM high time over a 2^WIN_W window. Optional: MOTOR_DECODE_SYNC_EN (input synchronizers).
module motor_pwm_decode
  import motor_pkg::*;
#(
  parameter int unsigned WIN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fwd_lft,
  input  logic                 rev_lft,
  input  logic                 fwd_rht,
  input  logic                 rev_rht,
  output logic signed [WIN_W:0] lft_meas,
  output logic signed [WIN_W:0] rht_meas,
  output logic                 lft_brk,
  output logic                 rht_brk,
  output logic                 lft_flt,
  output logic                 rht_flt,
  output logic                 meas_vld
);

  logic [WIN_W-1:0] win_cnt_q;
  logic             win_end;
  logic             meas_vld_q;

  assign win_end = &win_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q  <= '0;
      meas_vld_q <= 1'b0;
    end else begin
      win_cnt_q  <= win_cnt_q + WIN_W'(1);
      meas_vld_q <= win_end;
    end
  end

  assign meas_vld = meas_vld_q;

  motor_chan_meas #(
    .WIN_W(WIN_W)
  ) u_lft (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .fwd_i    (fwd_lft),
    .rev_i    (rev_lft),
    .win_end_i(win_end),
    .meas_o   (lft_meas),
    .brk_o    (lft_brk),
    .flt_o    (lft_flt)
  );

  motor_chan_meas #(
    .WIN_W(WIN_W)
  ) u_rht (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .fwd_i    (fwd_rht),
    .rev_i    (rev_rht),
    .win_end_i(win_end),
    .meas_o   (rht_meas),
    .brk_o    (rht_brk),
    .flt_o    (rht_flt)
  );

endmodule

// File: tb/tb_motor_pwm_decode.sv
// Self-checking bench for motor_pwm_decode: randomized drive patterns against a window-sum model.
module tb_motor_pwm_decode;

  localparam int WIN_W = 10;
  localparam int F     = 1 << WIN_W;
`ifdef MOTOR_DECODE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk, rst_n;
  logic        fwd_lft, rev_lft, fwd_rht, rev_rht;
  logic [10:0] lft_meas, rht_meas;
  logic        lft_brk, rht_brk, lft_flt, rht_flt, meas_vld;

  motor_pwm_decode #(
    .WIN_W(WIN_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .fwd_lft (fwd_lft),
    .rev_lft (rev_lft),
    .fwd_rht (fwd_rht),
    .rev_rht (rev_rht),
    .lft_meas(lft_meas),
    .rht_meas(rht_meas),
    .lft_brk (lft_brk),
    .rht_brk (rht_brk),
    .lft_flt (lft_flt),
    .rht_flt (rht_flt),
    .meas_vld(meas_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-line sample history, indexed by cycle number since reset release.
  bit hist [4][0:32767];
  int cyc;
  int win_idx;
  int duty  [4];
  int phase [4];
  bit noise;
  int pulse_at;

  task automatic set_pattern(input int d0, p0, d1, p1, d2, p2, d3, p3);
    duty[0] = d0; phase[0] = p0; duty[1] = d1; phase[1] = p1;
    duty[2] = d2; phase[2] = p2; duty[3] = d3; phase[3] = p3;
    noise = 1'b0;
    pulse_at = -1;
  endtask

  task automatic step();
    bit v [4];
    for (int i = 0; i < 4; i++) begin
      if (noise) v[i] = ($urandom_range(0, 3) != 0);
      else       v[i] = (((cyc + phase[i]) % F) < duty[i]);
    end
    if (cyc == pulse_at) v[0] = 1'b1;
    fwd_lft = v[0]; rev_lft = v[1]; fwd_rht = v[2]; rev_rht = v[3];
    for (int i = 0; i < 4; i++) hist[i][cyc] = v[i];
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_window(output int stray, output bit vld_end);
    stray = 0;
    for (int n = 0; n < F; n++) begin
      step();
      if ((cyc % F) != 0 && meas_vld) stray++;
    end
    vld_end = meas_vld;
  endtask

  // Expected outputs for window k of a side, straight from the classification rules.
  function automatic void model(input int k, input int side, output logic [10:0] m,
                                output bit b, output bit f);
    int fc = 0, rc = 0, meas = 0, idx;
    for (int i = 0; i < F; i++) begin
      idx = k * F + i - LAT;
      if (idx >= 0) begin
        fc += int'(hist[side*2][idx]);
        rc += int'(hist[side*2+1][idx]);
      end
    end
    b = 1'b0; f = 1'b0;
    if (fc == F && rc == F) b = 1'b1;
    else if (rc == 0)       meas = (fc > F - 1) ? F - 1 : fc;
    else if (fc == 0)       meas = -((rc > F - 1) ? F - 1 : rc);
    else                    f = 1'b1;
    m = 11'(meas);
  endfunction

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    win_idx = 0;
  endtask

  task automatic test_reset();
    set_pattern(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    fwd_lft = 0; rev_lft = 0; fwd_rht = 0; rev_rht = 0;
    repeat (3) @(posedge clk);
    release_reset();
    n_cmp++;
    if ({lft_meas, rht_meas, lft_brk, rht_brk, lft_flt, rht_flt, meas_vld} !== 27'd0) begin
      n_bad++;
      $display("FAIL reset_state: got lm=%h rm=%h flags=%b%b%b%b vld=%b, required all 0",
               lft_meas, rht_meas, lft_brk, rht_brk, lft_flt, rht_flt, meas_vld);
    end
  endtask

  task automatic test_windows(input string name, input int nwin, input int lit_side,
                              input logic [12:0] lit);
    int stray;
    bit vld;
    logic [10:0] el, er;
    bit elb, elf, erb, erf;
    for (int w = 0; w < nwin; w++) begin
      run_window(stray, vld);
      model(win_idx, 0, el, elb, elf);
      model(win_idx, 1, er, erb, erf);
      win_idx++;
      n_cmp++;
      if (!vld || stray != 0) begin
        n_bad++;
        $display("FAIL %s_vld w%0d: vld=%b stray=%0d, required vld=1 stray=0",
                 name, w, vld, stray);
      end
      n_cmp++;
      if ({lft_meas, lft_brk, lft_flt} !== {el, elb, elf}) begin
        n_bad++;
        $display("FAIL %s_lft w%0d: got %h/%b/%b, required %h/%b/%b", name, w,
                 lft_meas, lft_brk, lft_flt, el, elb, elf);
      end
      n_cmp++;
      if ({rht_meas, rht_brk, rht_flt} !== {er, erb, erf}) begin
        n_bad++;
        $display("FAIL %s_rht w%0d: got %h/%b/%b, required %h/%b/%b", name, w,
                 rht_meas, rht_brk, rht_flt, er, erb, erf);
      end
      // Steady patterns are also held to hand-computed values once a full window has elapsed.
      if (w >= 1 && lit_side == 0) begin
        n_cmp++;
        if ({lft_meas, lft_brk, lft_flt} !== lit) begin
          n_bad++;
          $display("FAIL %s_lft_const w%0d: got %h/%b/%b, required %h", name, w,
                   lft_meas, lft_brk, lft_flt, lit);
        end
      end else if (w >= 1 && lit_side == 1) begin
        n_cmp++;
        if ({rht_meas, rht_brk, rht_flt} !== lit) begin
          n_bad++;
          $display("FAIL %s_rht_const w%0d: got %h/%b/%b, required %h", name, w,
                   rht_meas, rht_brk, rht_flt, lit);
        end
      end
    end
  endtask

  task automatic test_duty();
    set_pattern(300, $urandom_range(0, F - 1), 0, 0, 0, 0, 512, $urandom_range(0, F - 1));
    test_windows("fwd300", 3, 0, {11'h12C, 2'b00});
    set_pattern(300, 0, 0, 0, 0, 0, 512, $urandom_range(0, F - 1));
    test_windows("rev512", 2, 1, {11'h600, 2'b00});
  endtask

  task automatic test_brake_coast();
    set_pattern(F, 0, F, 0, 0, 0, 0, 0);
    test_windows("brake", 2, 0, {11'h000, 2'b10});
    set_pattern(0, 0, 0, 0, 0, 0, 0, 0);
    test_windows("coast", 2, 0, {11'h000, 2'b00});
  endtask

  task automatic test_sat_fault();
    set_pattern(F, 0, 0, 0, 0, 0, F, 0);
    test_windows("sat", 2, 1, {11'h401, 2'b00});
    // rev_lft starts 80 cycles into fwd_lft's 100-cycle pulse: 20-cycle overlap.
    set_pattern(100, 0, 100, F - 80, 0, 0, 0, 0);
    test_windows("fault", 2, 0, {11'h000, 2'b01});
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int kind = $urandom_range(0, 2);
      set_pattern(0, 0, 0, 0, 0, 0, 0, 0);
      for (int s = 0; s < 2; s++) begin
        int d = $urandom_range(0, F);
        if (kind == 0 || (kind == 2 && s == 0)) begin
          duty[s*2] = d; phase[s*2] = $urandom_range(0, F - 1);
        end else begin
          duty[s*2+1] = d; phase[s*2+1] = $urandom_range(0, F - 1);
        end
      end
      test_windows("rand", 1, 2, 13'd0);
    end
    set_pattern(0, 0, 0, 0, 0, 0, 0, 0);
    noise = 1'b1;
    test_windows("noise", 2, 2, 13'd0);
    noise = 1'b0;
  endtask

  task automatic test_mid_reset();
    set_pattern(300, 0, 0, 0, 0, 0, 0, 0);
    test_windows("pre_rst", 1, 2, 13'd0);
    for (int n = 0; n < 600; n++) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({lft_meas, rht_meas, lft_brk, rht_brk, lft_flt, rht_flt, meas_vld} !== 27'd0) begin
      n_bad++;
      $display("FAIL mid_reset_clear: got lm=%h rm=%h vld=%b, required all 0",
               lft_meas, rht_meas, meas_vld);
    end
    release_reset();
    set_pattern(700, $urandom_range(0, F - 1), 0, 0, 0, 0, 0, 0);
    test_windows("post_rst", 2, 2, 13'd0);
  endtask

  task automatic test_single_pulse();
    logic [10:0] first, second;
    int stray;
    bit vld;
    set_pattern(0, 0, 0, 0, 0, 0, 0, 0);
    test_windows("pulse_pre", 1, 2, 13'd0);
    pulse_at = cyc + F - 1;
    run_window(stray, vld);
    first = lft_meas;
    run_window(stray, vld);
    second = lft_meas;
    win_idx += 2;
`ifdef MOTOR_DECODE_SYNC_EN
    n_cmp++;
    if ({first, second} !== {11'd0, 11'd1}) begin
      n_bad++;
      $display("FAIL pulse_shift: got N=%h N+1=%h, required N=000 N+1=001", first, second);
    end
`else
    n_cmp++;
    if ({first, second} !== {11'd1, 11'd0}) begin
      n_bad++;
      $display("FAIL pulse_last: got N=%h N+1=%h, required N=001 N+1=000", first, second);
    end
`endif
  endtask

  initial begin
    cyc = 0;
    win_idx = 0;
    test_reset();
    test_windows("first", 1, 2, 13'd0);
    test_duty();
    test_brake_coast();
    test_sat_fault();
    test_random();
    test_mid_reset();
    test_single_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
